// File: rtl/brg_cgra_xcel_cmd_unit.sv
// Command/CSR unit for one CGRA array: decodes endpoint loads/stores into CSRs and config RAM,
// streams config words to the array on launch, then sequences per-iteration go pulses.
module brg_cgra_xcel_cmd_unit #(
  parameter int addr_width_p    = 16,
  parameter int data_width_p    = 32,
  parameter int num_cfg_words_p = 16,
  parameter int cfg_base_p      = 'h100
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               in_v_i,
  output logic                               in_yumi_o,
  input  logic                               in_we_i,
  input  logic [addr_width_p-1:0]            in_addr_i,
  input  logic [data_width_p-1:0]            in_data_i,
  input  logic [data_width_p/8-1:0]          in_mask_i,
  output logic                               returning_v_o,
  output logic [data_width_p-1:0]            returning_data_o,
  output logic                               cfg_v_o,
  input  logic                               cfg_ready_i,
  output logic [$clog2(num_cfg_words_p)-1:0] cfg_idx_o,
  output logic [data_width_p-1:0]            cfg_data_o,
  output logic                               go_o,
  input  logic                               done_i,
  output logic                               busy_o
);

  localparam int mask_width_lp = data_width_p / 8;
  localparam int idx_width_lp  = $clog2(num_cfg_words_p);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_e;

  state_e                  state_r, state_n;
  logic [data_width_p-1:0] cfg_mem [num_cfg_words_p];
  logic [idx_width_lp-1:0] cfg_idx_r;
  logic [data_width_p-1:0] iter_r, cycles_r, remaining_r;
  logic                    err_r, go_r, ret_v_r;
  logic [data_width_p-1:0] ret_data_r, rd_data;

  logic                    wr, busy, launch, status_wr, err_set;
  logic                    hit_go, hit_status, hit_iter, hit_cycles, hit_cfg;
  logic [addr_width_p-1:0] cfg_off;
  logic [idx_width_lp-1:0] cfg_sel;
  logic                    cfg_last_beat, last_iter;

  function automatic logic [data_width_p-1:0] merge_bytes(
    input logic [data_width_p-1:0]  old_word,
    input logic [data_width_p-1:0]  new_word,
    input logic [mask_width_lp-1:0] mask
  );
    logic [data_width_p-1:0] result;
    result = old_word;
    for (int b = 0; b < mask_width_lp; b++) begin
      if (mask[b]) result[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return result;
  endfunction

  assign in_yumi_o  = in_v_i & ~reset_i;
  assign wr         = in_yumi_o & in_we_i;
  assign busy       = (state_r == CFG) || (state_r == RUN);

  assign hit_go     = in_addr_i == addr_width_p'(0);
  assign hit_status = in_addr_i == addr_width_p'(1);
  assign hit_iter   = in_addr_i == addr_width_p'(2);
  assign hit_cycles = in_addr_i == addr_width_p'(3);
  assign cfg_off    = in_addr_i - addr_width_p'(cfg_base_p);
  assign hit_cfg    = cfg_off < addr_width_p'(num_cfg_words_p);
  assign cfg_sel    = cfg_off[idx_width_lp-1:0];

  // Stores that would disturb a launch in flight are dropped and flagged instead.
  assign launch        = wr & hit_go & in_data_i[0] & ~busy;
  assign status_wr     = wr & hit_status;
  assign err_set       = wr & busy & (hit_go | hit_iter | hit_cfg);
  assign cfg_last_beat = (state_r == CFG) && cfg_ready_i &&
                         (cfg_idx_r == idx_width_lp'(num_cfg_words_p - 1));
  assign last_iter     = remaining_r <= data_width_p'(1);

  always_comb begin
    rd_data = '0;
    if (hit_status)      rd_data[2:0] = {err_r, state_r == DONE, busy};
    else if (hit_iter)   rd_data = iter_r;
    else if (hit_cycles) rd_data = cycles_r;
    else if (hit_cfg)    rd_data = cfg_mem[cfg_sel];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (launch) state_n = CFG;
      CFG:  if (cfg_last_beat) state_n = RUN;
      RUN:  if (done_i && last_iter) state_n = DONE;
      DONE: begin
        if (launch)         state_n = CFG;
        else if (status_wr) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cfg_idx_r   <= '0;
      iter_r      <= data_width_p'(1);
      cycles_r    <= '0;
      remaining_r <= '0;
      err_r       <= 1'b0;
      go_r        <= 1'b0;
      ret_v_r     <= 1'b0;
      ret_data_r  <= '0;
    end else begin
      ret_v_r    <= in_yumi_o;
      ret_data_r <= (in_yumi_o && !in_we_i) ? rd_data : '0;
      go_r       <= cfg_last_beat || ((state_r == RUN) && done_i && !last_iter);

      if (launch)                           cfg_idx_r <= '0;
      else if (state_r == CFG && cfg_ready_i) cfg_idx_r <= cfg_idx_r + 1'b1;

      // A zero iteration count still runs the array once.
      if (launch) begin
        cycles_r    <= '0;
        remaining_r <= (iter_r == '0) ? data_width_p'(1) : iter_r;
      end else begin
        if (busy && cycles_r != '1)       cycles_r    <= cycles_r + 1'b1;
        if (state_r == RUN && done_i)     remaining_r <= remaining_r - 1'b1;
      end

      if (wr && hit_iter && !busy) iter_r <= merge_bytes(iter_r, in_data_i, in_mask_i);

      if (err_set)        err_r <= 1'b1;
      else if (status_wr) err_r <= 1'b0;
    end
  end

  // Config RAM has no reset; its contents are only meaningful once written.
  always_ff @(posedge clk_i) begin
    if (wr && hit_cfg && !busy)
      cfg_mem[cfg_sel] <= merge_bytes(cfg_mem[cfg_sel], in_data_i, in_mask_i);
  end

  assign returning_v_o    = ret_v_r;
  assign returning_data_o = ret_data_r;
  assign cfg_v_o          = state_r == CFG;
  assign cfg_idx_o        = cfg_idx_r;
  assign cfg_data_o       = cfg_mem[cfg_idx_r];
  assign go_o             = go_r;
  assign busy_o           = busy;

endmodule

// File: tb/tb_brg_cgra_xcel_cmd_unit.sv
// Directed bench for brg_cgra_xcel_cmd_unit: drives endpoint requests and a simple CGRA responder,
// comparing responses and config/go traffic against hand-computed values.
module tb_brg_cgra_xcel_cmd_unit;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        in_v_i = 1'b0;
  logic        in_yumi_o;
  logic        in_we_i = 1'b0;
  logic [15:0] in_addr_i = '0;
  logic [31:0] in_data_i = '0;
  logic [3:0]  in_mask_i = '0;
  logic        returning_v_o;
  logic [31:0] returning_data_o;
  logic        cfg_v_o;
  logic        cfg_ready_i = 1'b1;
  logic [3:0]  cfg_idx_o;
  logic [31:0] cfg_data_o;
  logic        go_o;
  logic        done_i = 1'b0;
  logic        busy_o;

  int checks = 0;
  int failures = 0;

  int          beat_cnt = 0;
  logic [3:0]  beat_idx [16];
  logic [31:0] beat_data [16];
  int          go_cnt = 0;
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [3:0]  prev_idx = '0;
  int          done_gap = 3;
  int          done_cnt = 0;
  logic        ready_toggle = 1'b0;
  logic [31:0] rdata;

  brg_cgra_xcel_cmd_unit dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .in_v_i(in_v_i), .in_yumi_o(in_yumi_o), .in_we_i(in_we_i),
    .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_mask_i(in_mask_i),
    .returning_v_o(returning_v_o), .returning_data_o(returning_data_o),
    .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_idx_o(cfg_idx_o),
    .cfg_data_o(cfg_data_o), .go_o(go_o), .done_i(done_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Ready changes just after each rising edge so the negedge monitor sees settled values.
  always @(posedge clk_i) begin
    #2;
    if (ready_toggle) cfg_ready_i = ~cfg_ready_i;
    else              cfg_ready_i = 1'b1;
  end

  // Monitor config beats, go pulses and idx stability; also emulate the array's done pulse.
  always @(negedge clk_i) begin
    if (prev_stall && (!cfg_v_o || cfg_idx_o != prev_idx)) hold_viol++;
    prev_stall = cfg_v_o && !cfg_ready_i;
    prev_idx   = cfg_idx_o;
    if (cfg_v_o && cfg_ready_i) begin
      if (beat_cnt < 16) begin
        beat_idx[beat_cnt]  = cfg_idx_o;
        beat_data[beat_cnt] = cfg_data_o;
      end
      beat_cnt++;
    end
    done_i = 1'b0;
    if (go_o) begin
      go_cnt++;
      done_cnt = done_gap;
    end else if (done_cnt != 0) begin
      done_cnt--;
      if (done_cnt == 0) done_i = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [31:0] data,
                               input logic [3:0] mask, output logic [31:0] rd);
    @(negedge clk_i);
    in_v_i = 1'b1; in_we_i = we; in_addr_i = addr; in_data_i = data; in_mask_i = mask;
    #1 checkOutput("yumi", {31'b0, in_yumi_o}, 32'd1);
    @(negedge clk_i);
    in_v_i = 1'b0; in_we_i = 1'b0;
    checkOutput("ret_v", {31'b0, returning_v_o}, 32'd1);
    rd = returning_data_o;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("idle_timeout", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic waitGo();
    int n = 0;
    while (go_cnt == 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("go_timeout", {31'b0, go_cnt == 0}, 32'd0);
  endtask

  task automatic clearMonitor();
    beat_cnt = 0;
    go_cnt   = 0;
    hold_viol = 0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk_i);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst_cfgv", {31'b0, cfg_v_o}, 32'd0);
    checkOutput("rst_go",   {31'b0, go_o}, 32'd0);
    checkOutput("rst_retv", {31'b0, returning_v_o}, 32'd0);
    reset_i = 1'b0;
    applyStimulus(1'b0, 16'h2, '0, 4'h0, rdata); checkOutput("rst_iter", rdata, 32'd1);
    applyStimulus(1'b0, 16'h1, '0, 4'h0, rdata); checkOutput("rst_status", rdata, 32'd0);
    applyStimulus(1'b0, 16'h3, '0, 4'h0, rdata); checkOutput("rst_cycles", rdata, 32'd0);

    // Full launch with ready held high.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 16'h100 + 16'(k), 32'(k * 3), 4'hF, rdata);
      if (k == 0) checkOutput("store_rdata", rdata, 32'd0);
    end
    applyStimulus(1'b1, 16'h2, 32'd2, 4'hF, rdata);
    clearMonitor();
    applyStimulus(1'b1, 16'h0, 32'd1, 4'hF, rdata);
    waitIdle();
    checkOutput("beats", beat_cnt, 32'd16);
    for (int k = 0; k < 16; k++) begin
      checkOutput("beat_idx", {28'b0, beat_idx[k]}, 32'(k));
      checkOutput("beat_data", beat_data[k], 32'(k * 3));
    end
    checkOutput("go_cnt2", go_cnt, 32'd2);
    applyStimulus(1'b0, 16'h1, '0, 4'h0, rdata); checkOutput("status_done", rdata, 32'd2);
    applyStimulus(1'b0, 16'h3, '0, 4'h0, rdata); checkOutput("cycles24", rdata, 32'd24);

    // Launch again from DONE with a stalling array.
    ready_toggle = 1'b1;
    clearMonitor();
    applyStimulus(1'b1, 16'h0, 32'd1, 4'hF, rdata);
    waitIdle();
    ready_toggle = 1'b0;
    checkOutput("tgl_beats", beat_cnt, 32'd16);
    checkOutput("tgl_hold", hold_viol, 32'd0);
    checkOutput("tgl_idx15", {28'b0, beat_idx[15]}, 32'd15);
    checkOutput("tgl_data7", beat_data[7], 32'd21);
    applyStimulus(1'b0, 16'h3, '0, 4'h0, rdata);
    checkOutput("tgl_cyc_ge32", {31'b0, rdata >= 32'd32}, 32'd1);

    // Stores while busy are dropped and flag ERR.
    applyStimulus(1'b1, 16'h2, 32'd1, 4'hF, rdata);
    done_gap = 30;
    clearMonitor();
    applyStimulus(1'b1, 16'h0, 32'd1, 4'hF, rdata);
    waitGo();
    applyStimulus(1'b1, 16'h2, 32'd5, 4'hF, rdata);
    applyStimulus(1'b0, 16'h2, '0, 4'h0, rdata); checkOutput("busy_iter", rdata, 32'd1);
    applyStimulus(1'b0, 16'h1, '0, 4'h0, rdata); checkOutput("busy_err", rdata, 32'd5);
    applyStimulus(1'b1, 16'h1, '0, 4'hF, rdata);
    applyStimulus(1'b0, 16'h1, '0, 4'h0, rdata); checkOutput("err_clr", rdata, 32'd1);
    waitIdle();
    done_gap = 3;
    checkOutput("busy_go_cnt", go_cnt, 32'd1);
    applyStimulus(1'b1, 16'h1, '0, 4'hF, rdata);
    applyStimulus(1'b0, 16'h1, '0, 4'h0, rdata); checkOutput("done_clr", rdata, 32'd0);

    // Masked config store.
    applyStimulus(1'b1, 16'h103, 32'h0, 4'hF, rdata);
    applyStimulus(1'b1, 16'h103, 32'hAABBCCDD, 4'b0101, rdata);
    applyStimulus(1'b0, 16'h103, '0, 4'h0, rdata); checkOutput("mask_cfg3", rdata, 32'h00BB00DD);
    applyStimulus(1'b1, 16'h2, 32'h0000_0304, 4'b0001, rdata);
    applyStimulus(1'b0, 16'h2, '0, 4'h0, rdata); checkOutput("mask_iter", rdata, 32'h4);

    // ITER=0 runs once; unmapped load returns zero.
    applyStimulus(1'b1, 16'h2, 32'd0, 4'hF, rdata);
    clearMonitor();
    applyStimulus(1'b1, 16'h0, 32'd1, 4'hF, rdata);
    waitIdle();
    checkOutput("iter0_go", go_cnt, 32'd1);
    applyStimulus(1'b0, 16'h50, '0, 4'h0, rdata); checkOutput("unmapped", rdata, 32'd0);

    // Reset while running.
    applyStimulus(1'b1, 16'h2, 32'd3, 4'hF, rdata);
    done_gap = 30;
    clearMonitor();
    applyStimulus(1'b1, 16'h0, 32'd1, 4'hF, rdata);
    waitGo();
    reset_i = 1'b1;
    @(negedge clk_i);
    checkOutput("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("mid_rst_go",   {31'b0, go_o}, 32'd0);
    checkOutput("mid_rst_cfgv", {31'b0, cfg_v_o}, 32'd0);
    reset_i = 1'b0;
    done_gap = 3;
    applyStimulus(1'b0, 16'h1, '0, 4'h0, rdata); checkOutput("mid_rst_status", rdata, 32'd0);
    applyStimulus(1'b0, 16'h2, '0, 4'h0, rdata); checkOutput("mid_rst_iter", rdata, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
